// File: rtl/cla_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined CLA subtractor.
package cla_pkg;

    localparam int CLA_SLICE_W = 4;
    localparam int CLA_MAX_W   = 64;

    // Sized for the widest legal configuration; bits above WIDTH stay zero and are trimmed in synthesis.
    typedef struct packed {
        logic                 vld;
        logic                 carry;
        logic                 ovf;
        logic [CLA_MAX_W-1:0] a;
        logic [CLA_MAX_W-1:0] b;
        logic [CLA_MAX_W-1:0] d;
    } stage_t;

endpackage

// File: rtl/cla_slice4.sv
// Purpose: combinational 4-bit carry look-ahead adder slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
module cla_slice4
    import cla_pkg::*;
(
    input  logic [CLA_SLICE_W-1:0] a,
    input  logic [CLA_SLICE_W-1:0] b,
    input  logic                   ci,
    output logic [CLA_SLICE_W-1:0] s,
    output logic                   co,
    output logic                   co_msb_in
);

    logic [CLA_SLICE_W-1:0] g;
    logic [CLA_SLICE_W-1:0] p;
    logic [CLA_SLICE_W:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        // Every carry is flattened to generate/propagate terms of ci, no ripple.
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s         = p ^ c[CLA_SLICE_W-1:0];
        co        = c[4];
        co_msb_in = c[3];
    end

endmodule

// File: rtl/cla_pipelined_subtractor.sv
// Purpose: {Bout,D} = A - B - Bin, one 4-bit CLA slice per pipeline stage; optional OVF port via CLA_SUB_OVF_EN.
// Latency: WIDTH/4 cycles from input transfer to out_valid, one result per cycle.
// Backpressure: all stages freeze while out_valid && !out_ready; in_ready = ~out_valid | out_ready.
module cla_pipelined_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NSTAGES = WIDTH / CLA_SLICE_W;

    // Register 0 captures raw operands; register k+1 holds the result of slice k.
    stage_t st_q [NSTAGES+1];
    stage_t st_d [NSTAGES+1];

    logic [CLA_SLICE_W-1:0] sum_w [NSTAGES];
    logic [NSTAGES-1:0]     cout_w;
    logic [NSTAGES-1:0]     cmsb_w;
    logic                   adv;
    logic                   unused_tail;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_slice
        cla_slice4 u_slice (
            .a         (st_q[k].a[k*CLA_SLICE_W +: CLA_SLICE_W]),
            .b         (~st_q[k].b[k*CLA_SLICE_W +: CLA_SLICE_W]),
            .ci        (st_q[k].carry),
            .s         (sum_w[k]),
            .co        (cout_w[k]),
            .co_msb_in (cmsb_w[k])
        );
    end

    always_comb begin
        st_d[0]                = '0;
        st_d[0].vld            = in_valid;
        st_d[0].carry          = ~Bin;
        st_d[0].a[WIDTH-1:0]   = A;
        st_d[0].b[WIDTH-1:0]   = B;
        for (int k = 0; k < NSTAGES; k++) begin
            st_d[k+1]                                   = st_q[k];
            st_d[k+1].d[k*CLA_SLICE_W +: CLA_SLICE_W]   = sum_w[k];
            st_d[k+1].carry                             = cout_w[k];
        end
        // The output register keeps the borrow rather than the carry so reset reads Bout = 0.
        st_d[NSTAGES].carry = ~cout_w[NSTAGES-1];
`ifdef CLA_SUB_OVF_EN
        st_d[NSTAGES].ovf   = cmsb_w[NSTAGES-1] ^ cout_w[NSTAGES-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= NSTAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k <= NSTAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    always_comb begin
        adv       = ~st_q[NSTAGES].vld | out_ready;
        in_ready  = adv;
        out_valid = st_q[NSTAGES].vld;
        D         = st_q[NSTAGES].d[WIDTH-1:0];
        Bout      = st_q[NSTAGES].carry;
`ifdef CLA_SUB_OVF_EN
        OVF       = st_q[NSTAGES].ovf;
`endif
    end

    assign unused_tail = ^{st_q[NSTAGES].a, st_q[NSTAGES].b, st_q[NSTAGES].d,
                           st_q[NSTAGES].ovf, cmsb_w};

endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// Randomized and directed bench for cla_pipelined_subtractor (WIDTH=16) against an arithmetic reference model.
module tb_cla_pipelined_subtractor;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
`ifdef CLA_SUB_OVF_EN
    logic         OVF;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cla_pipelined_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef CLA_SUB_OVF_EN
        ,
        .OVF       (OVF)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on (W+1)-bit unsigned values; bit W is the borrow.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa - sb - int'(bin);
        return (r > 32767) || (r < -32768);
    endfunction

    // Send one operand with out_ready high and report cycles until out_valid (0 = timed out).
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = a; B = b; Bin = bin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) begin
                lat = i - 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0 && out_valid) lat = 20;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || D !== '0 || Bout !== 1'b0)
            $display("FAIL reset_outputs: out_valid=%b D=%h Bout=%b, need 0/0000/0", out_valid, D, Bout);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b need 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [W-1:0] va [3] = '{16'h0005, 16'h0000, 16'hFFFF};
        logic [W-1:0] vb [3] = '{16'h0003, 16'h0001, 16'hFFFF};
        logic         vi [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] ed [3] = '{16'h0002, 16'hFFFF, 16'hFFFF};
        logic         eb [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            send_one(va[i], vb[i], vi[i], lat);
            n_checks++;
            if (lat != LAT) $display("FAIL dir%0d_latency: got %0d need %0d", i, lat, LAT);
            else n_pass++;
            n_checks++;
            if (D !== ed[i] || Bout !== eb[i])
                $display("FAIL dir%0d_result: D=%h Bout=%b, need D=%h Bout=%b", i, D, Bout, ed[i], eb[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

`ifdef CLA_SUB_OVF_EN
    task automatic test_ovf;
        logic [W-1:0] va [2] = '{16'h8000, 16'h7FFF};
        logic [W-1:0] ed [2] = '{16'h7FFF, 16'h7FFE};
        logic         eo [2] = '{1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            send_one(va[i], 16'h0001, 1'b0, lat);
            n_checks++;
            if (lat != LAT || D !== ed[i] || OVF !== eo[i])
                $display("FAIL ovf%0d: lat=%0d D=%h OVF=%b, need lat=%0d D=%h OVF=%b",
                         i, lat, D, OVF, LAT, ed[i], eo[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask
`endif

    // Drives n operands with optional random gaps/stalls; scripted=1 gives back-to-back with a 3-cycle stall at cycle 6.
    task automatic run_stream(input int n, input bit scripted);
        logic [W-1:0] va [$];
        logic [W-1:0] vb [$];
        logic         vi [$];
        logic [W+1:0] exp_q [$];
        logic [W+1:0] e;
        logic [W-1:0] d_hold;
        int sent = 0;
        int got  = 0;
        for (int i = 0; i < n; i++) begin
            va.push_back(W'($urandom));
            vb.push_back(W'($urandom));
            vi.push_back(1'($urandom));
        end
        for (int c = 0; c < 600 && got < n; c++) begin
            in_valid  = (sent < n) && (scripted || ($urandom_range(0, 3) != 0));
            A = va[sent < n ? sent : 0]; B = vb[sent < n ? sent : 0]; Bin = vi[sent < n ? sent : 0];
            out_ready = scripted ? !(c >= 6 && c < 9) : ($urandom_range(0, 2) != 0);
            #1;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_checks++;
                $display("FAIL in_ready_rule: cycle %0d got %b need %b", c, in_ready, !out_valid || out_ready);
            end
            if (scripted && c == 6) begin
                d_hold = D;
                n_checks++;
                if (out_valid !== 1'b1) $display("FAIL stall_start_valid: got %b need 1", out_valid);
                else n_pass++;
            end
            if (scripted && c >= 7 && c <= 9) begin
                n_checks++;
                if (out_valid !== 1'b1 || D !== d_hold)
                    $display("FAIL stall_hold: cycle %0d out_valid=%b D=%h need 1/%h", c, out_valid, D, d_hold);
                else n_pass++;
            end
            if (in_valid && in_ready) begin
                e = {ref_ovf(va[sent], vb[sent], vi[sent]), ref_sub(va[sent], vb[sent], vi[sent])};
                exp_q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: unexpected result D=%h", D);
                end else begin
                    e = exp_q.pop_front();
`ifdef CLA_SUB_OVF_EN
                    if ({OVF, Bout, D} !== e)
                        $display("FAIL stream_result%0d: OVF=%b Bout=%b D=%h need %b/%b/%h",
                                 got, OVF, Bout, D, e[W+1], e[W], e[W-1:0]);
`else
                    if ({Bout, D} !== e[W:0])
                        $display("FAIL stream_result%0d: Bout=%b D=%h need %b/%h", got, Bout, D, e[W], e[W-1:0]);
`endif
                    else n_pass++;
                end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != n || exp_q.size() != 0)
            $display("FAIL stream_count: got %0d results, %0d pending, need %0d and 0", got, exp_q.size(), n);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        run_stream(20, 1'b1);
    endtask

    task automatic test_random_flow;
        run_stream(30, 1'b0);
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   e;
        int lat;
        int extra = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; A = W'($urandom); B = W'($urandom); Bin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL midflight_pre: out_valid=%b need 1", out_valid);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || D !== '0 || Bout !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midflight_reset: out_valid=%b D=%h Bout=%b in_ready=%b need 0/0000/0/1",
                     out_valid, D, Bout, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midflight_release_ready: got %b need 1", in_ready);
        else n_pass++;
        a = W'($urandom); b = W'($urandom);
        e = ref_sub(a, b, 1'b1);
        send_one(a, b, 1'b1, lat);
        n_checks++;
        if (lat != LAT || {Bout, D} !== e)
            $display("FAIL midflight_single: lat=%0d Bout=%b D=%h need lat=%0d %b/%h", lat, Bout, D, LAT, e[W], e[W-1:0]);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL midflight_extra: %0d extra result cycles, need 0", extra);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef CLA_SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_random_flow();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cla_pipelined_subtractor.md
CLA_PIPELINED_SUBTRACTOR -- requirements
Module: cla_pipelined_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL derive localparam NSTAGES = WIDTH/4, meaning pipeline depth with one 4-bit slice per stage.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operands are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports A and B, inputs, WIDTH bits: minuend and subtrahend, unsigned or two's complement.
REQ-008 The block SHALL have port Bin, input, 1 bit: borrow in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The block SHALL have port D, output, WIDTH bits: the difference.
REQ-012 The block SHALL have port Bout, output, 1 bit: borrow out.

Function
REQ-013 D and Bout SHALL satisfy {Bout, D} = A - B - Bin, computed modulo 2^(WIDTH+1) as A + ~B + ~Bin, with Bout = ~carry_out.
REQ-014 Stage k (k = 0..NSTAGES-1) SHALL compute bits [4k+3:4k] using a 4-bit carry look-ahead slice fed by the registered carry from stage k-1; stage 0 SHALL use carry-in ~Bin.
REQ-015 Operand slices not yet consumed SHALL travel with their transaction through the stage registers; completed result slices SHALL also be carried forward.
REQ-016 A transfer SHALL occur on an edge where valid and ready are both high, at the input and at the output alike.
REQ-017 Global advance SHALL be defined as adv = ~out_valid | out_ready; every stage register SHALL load only when adv is high.
REQ-018 in_ready SHALL equal adv, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-019 Latency SHALL be exactly NSTAGES cycles from the input transfer to out_valid, with no stall in between; throughput SHALL be one result per cycle.
REQ-020 While out_valid is high and out_ready is low, D, Bout and out_valid SHALL hold stable and no stage SHALL advance.
REQ-021 Bubbles (in_valid low while adv is high) SHALL propagate as invalid stages; bubbles SHALL NOT be collapsed.
REQ-022 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-023 On rst high, all stage valid bits and out_valid SHALL be 0 immediately, and D, Bout and internal carries SHALL be 0.
REQ-024 A reset asserted mid-operation SHALL discard every in-flight transaction; the first input transfer after release SHALL produce the next out_valid.
REQ-025 in_ready SHALL be 1 while in reset and in the first cycle after release.

Configuration
REQ-026 With macro CLA_SUB_OVF_EN defined, the block SHALL add port OVF, output, 1 bit, registered in step with D, equal to carry-into-MSB XOR carry-out-of-MSB (signed overflow), reset to 0.
REQ-027 Without CLA_SUB_OVF_EN, the OVF port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package cla_pkg SHALL hold CLA_SLICE_W = 4 and a stage record typedef (valid, carry, operand slices, partial difference).
REQ-029 Sub-module cla_slice4 SHALL implement the combinational 4-bit carry look-ahead adder: inputs a[3:0], b[3:0], ci; outputs s[3:0], co, co_msb_in.
REQ-030 The top level SHALL instantiate NSTAGES cla_slice4 instances and SHALL contain all sequential logic.

Verification
REQ-031 With WIDTH=16, inputs A=0x0005, B=0x0003, Bin=0 SHALL produce D=0x0002 and Bout=0 after 4 cycles.
REQ-032 A=0x0000, B=0x0001, Bin=0 SHALL produce D=0xFFFF and Bout=1; A=0xFFFF, B=0xFFFF, Bin=1 SHALL produce D=0xFFFF and Bout=1.
REQ-033 With CLA_SUB_OVF_EN defined, A=0x8000, B=0x0001 SHALL produce D=0x7FFF and OVF=1; A=0x7FFF, B=0x0001 SHALL produce OVF=0.
REQ-034 A back-to-back stream of 20 random operands, with out_ready held low for 3 cycles at cycle 6, SHALL produce 20 ordered, correct results, and D SHALL stay stable during the stall.
REQ-035 Asserting rst with 3 transactions in flight SHALL drop out_valid at once, and a single operand sent after release SHALL yield exactly one result, 4 cycles later.
